// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding and default widths.
package div_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned CW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when it does not borrow.
module div_step #(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] i_r,
    input  logic          i_q_msb,
    input  logic [DW-1:0] i_divisor,
    output logic [DW-1:0] o_r_nxt,
    output logic          o_q_bit
);

    logic [DW:0] w_shift;
    logic [DW:0] w_t;

    assign w_shift = {i_r, i_q_msb};
    assign w_t     = w_shift - {1'b0, i_divisor};

    // The partial remainder stays below the divisor, so the result always fits in DW bits.
    assign o_q_bit = ~w_t[DW];
    assign o_r_nxt = o_q_bit ? w_t[DW-1:0] : w_shift[DW-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, 2*DW / DW -> DW quotient + DW remainder, one quotient bit per clock,
// with valid/ready handshakes on input and output.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_by_zero,
    output logic            overflow
);

    state_t          r_state;
    state_t          w_state_nxt;

    logic [DW-1:0]   r_r;
    logic [DW-1:0]   r_q;
    logic [DW-1:0]   r_dvs;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_quotient;
    logic [DW-1:0]   r_remainder;
    logic            r_div_by_zero;
    logic            r_overflow;
    logic            r_in_ready;
    logic            r_out_valid;

    logic            w_err_dz;
    logic            w_err_ov;
    logic [DW-1:0]   w_r_nxt;
    logic            w_q_bit;
    logic [DW-1:0]   w_q_nxt;

    assign w_err_dz = (divisor == '0);
    assign w_err_ov = !w_err_dz && (dividend[2*DW-1:DW] >= divisor);
    assign w_q_nxt  = {r_q[DW-2:0], w_q_bit};

    div_step #(.DW(DW)) u_step (
        .i_r       (r_r),
        .i_q_msb   (r_q[DW-1]),
        .i_divisor (r_dvs),
        .o_r_nxt   (w_r_nxt),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = (w_err_dz || w_err_ov) ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath, result registers and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r           <= '0;
            r_q           <= '0;
            r_dvs         <= '0;
            r_cnt         <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dvs <= divisor;
                        if (w_err_dz) begin
                            r_quotient    <= '1;
                            r_remainder   <= dividend[DW-1:0];
                            r_div_by_zero <= 1'b1;
                            r_overflow    <= 1'b0;
                        end else if (w_err_ov) begin
                            r_quotient    <= '1;
                            r_remainder   <= '1;
                            r_div_by_zero <= 1'b0;
                            r_overflow    <= 1'b1;
                        end else begin
                            r_r           <= dividend[2*DW-1:DW];
                            r_q           <= dividend[DW-1:0];
                            r_cnt         <= CW'(DW);
                            r_div_by_zero <= 1'b0;
                            r_overflow    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_r   <= w_r_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_quotient  <= w_q_nxt;
                        r_remainder <= w_r_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

endmodule
